// File: rtl/priority_encoder_generic_if.sv
// rtl/priority_encoder_generic_if.sv - request/result bundle for the priority encoder (optional PRIO_ENC_ONEHOT_EN)
interface priority_encoder_generic_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0] x;
    logic         en;
    logic         z;
    logic [W-1:0] y;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [N-1:0] y_onehot;
`endif

`ifdef PRIO_ENC_ONEHOT_EN
    modport master (output x, output en, input z, input y, input y_onehot);
    modport slave  (input x, input en, output z, output y, output y_onehot);
`else
    modport master (output x, output en, input z, input y);
    modport slave  (input x, input en, output z, output y);
`endif
endinterface

// File: rtl/priority_encoder_generic.sv
// rtl/priority_encoder_generic.sv - registered MSB-first priority encoder with enable (optional PRIO_ENC_ONEHOT_EN)
module priority_encoder_generic #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    priority_encoder_generic_if.slave     bus
);
    localparam int W = $clog2(N);

    logic [W-1:0] w_idx;
    logic         w_any;
    logic [N-1:0] w_onehot;

    logic [W-1:0] r_y;
    logic         r_z;
    logic [N-1:0] r_onehot;

    // Scan upward so the highest set request overwrites every lower one
    always_comb begin
        w_idx    = '0;
        w_any    = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.x[i]) begin
                w_idx       = W'(i);
                w_any       = 1'b1;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Output register; a disabled encoder reports nothing regardless of x
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= '0;
            r_z      <= 1'b0;
            r_onehot <= '0;
        end else if (bus.en) begin
            r_y      <= w_idx;
            r_z      <= w_any;
            r_onehot <= w_onehot;
        end else begin
            r_y      <= '0;
            r_z      <= 1'b0;
            r_onehot <= '0;
        end
    end

    assign bus.y = r_y;
    assign bus.z = r_z;

`ifdef PRIO_ENC_ONEHOT_EN
    assign bus.y_onehot = r_onehot;
`else
    logic w_onehot_unused;
    assign w_onehot_unused = ^r_onehot;
`endif

endmodule

// File: tb/tb_priority_encoder_generic.sv
// tb/tb_priority_encoder_generic.sv - table-driven bench for priority_encoder_generic (N=4 and N=5)
module tb_priority_encoder_generic;
    logic clk;
    logic rst_n;

    priority_encoder_generic_if #(.N(4)) bus4 ();
    priority_encoder_generic_if #(.N(5)) bus5 ();

    priority_encoder_generic #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    priority_encoder_generic #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    typedef struct {
        logic       en;
        logic [3:0] x;
        logic [1:0] y;
        logic       z;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [1:0] ey, input logic ez);
        check({name, ".y"}, 32'(bus4.y), 32'(ey));
        check({name, ".z"}, 32'(bus4.z), 32'(ez));
`ifdef PRIO_ENC_ONEHOT_EN
        check({name, ".onehot"}, 32'(bus4.y_onehot), ez ? (32'd1 << ey) : 32'd0);
`endif
    endtask

    task automatic drive(input logic en, input logic [3:0] x);
        @(negedge clk);
        bus4.en = en;
        bus4.x  = x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n   = 1'b0;
        bus4.en = 1'b0;
        bus4.x  = '0;
        bus5.en = 1'b0;
        bus5.x  = '0;

        // Enabled sweep: expected index from hand-derived ranges
        for (int i = 0; i < 16; i++) begin
            v.en = 1'b1;
            v.x  = 4'(i);
            v.z  = (i != 0);
            if (i < 2)      v.y = 2'd0;
            else if (i < 4) v.y = 2'd1;
            else if (i < 8) v.y = 2'd2;
            else            v.y = 2'd3;
            vecs.push_back(v);
        end
        // Disabled: all-ones first, then a full sweep
        v.en = 1'b0; v.x = 4'b1111; v.y = 2'd0; v.z = 1'b0;
        vecs.push_back(v);
        for (int i = 0; i < 16; i++) begin
            v.en = 1'b0; v.x = 4'(i); v.y = 2'd0; v.z = 1'b0;
            vecs.push_back(v);
        end

        // Reset state, held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check4("reset_hold", 2'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check4("post_release_no_edge", 2'd0, 1'b0);

        // Table
        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].x);
            @(posedge clk);
            #1;
            check4($sformatf("vec%0d", k), vecs[k].y, vecs[k].z);
        end

        // Enable toggle with x=0110, checking the one-cycle lag of en
        drive(1'b1, 4'b0110);
        @(posedge clk); #1;
        check4("tog1", 2'd2, 1'b1);
        drive(1'b0, 4'b0110);
        #1;
        check4("tog_lag0", 2'd2, 1'b1);
        @(posedge clk); #1;
        check4("tog0", 2'd0, 1'b0);
        drive(1'b1, 4'b0110);
        #1;
        check4("tog_lag1", 2'd0, 1'b0);
        @(posedge clk); #1;
        check4("tog2", 2'd2, 1'b1);

        // Asynchronous reset mid-cycle with x=1000
        drive(1'b1, 4'b1000);
        @(posedge clk); #1;
        check4("pre_reset", 2'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_reset", 2'd0, 1'b0);
        @(posedge clk); #1;
        check4("reset_edge_hold", 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check4("rerelease_no_edge", 2'd0, 1'b0);
        @(posedge clk); #1;
        check4("first_capture", 2'd3, 1'b1);

        // Non-power-of-two width
        @(negedge clk);
        bus5.en = 1'b1;
        bus5.x  = 5'b10001;
        @(posedge clk); #1;
        check("n5_y", 32'(bus5.y), 32'd4);
        check("n5_z", 32'(bus5.z), 32'd1);
`ifdef PRIO_ENC_ONEHOT_EN
        check("n5_onehot", 32'(bus5.y_onehot), 32'b10000);
`endif
        @(negedge clk);
        bus5.x = 5'b00001;
        @(posedge clk); #1;
        check("n5_bit0_y", 32'(bus5.y), 32'd0);
        check("n5_bit0_z", 32'(bus5.z), 32'd1);
        @(negedge clk);
        bus5.x = 5'b01100;
        @(posedge clk); #1;
        check("n5_mid_y", 32'(bus5.y), 32'd3);
        @(negedge clk);
        bus5.x = 5'b00000;
        @(posedge clk); #1;
        check("n5_none_y", 32'(bus5.y), 32'd0);
        check("n5_none_z", 32'(bus5.z), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
